// File: rtl/muldiv_pkg.sv
// Shared types, constants and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } funct_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input funct_e f);
    case (f)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input funct_e f);
    case (f)
      MD_REM, MD_REMU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // MUL is treated as unsigned: its low product half is sign-independent.
  function automatic logic is_signed_a(input funct_e f);
    case (f)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input funct_e f);
    case (f)
      MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iteration engine: shift-add multiply or restoring divide on unsigned magnitudes.
// acc holds {product} or {remainder, quotient}; opnd holds the addend or divisor.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   load_opnd,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opnd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN-1:0]   div_diff_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] acc_next_s;

  // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    div_shift_s = acc_r[2*XLEN-1:XLEN-1];
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    div_diff_s  = div_shift_s[XLEN-1:0] - opnd_r;
    if (div_mode) begin
      if (div_ge_s) begin
        acc_next_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Operand load, iteration update and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r  <= 64'd0;
      opnd_r <= 32'd0;
      cnt_r  <= 5'd0;
    end else if (load) begin
      acc_r  <= {32'd0, load_lo};
      opnd_r <= load_opnd;
      cnt_r  <= 5'd0;
    end else if (step) begin
      acc_r  <= acc_next_s;
      cnt_r  <= cnt_r + 5'd1;
    end else begin
      acc_r  <= acc_r;
      opnd_r <= opnd_r;
      cnt_r  <= cnt_r;
    end
  end

  assign acc  = acc_r;
  assign last = (cnt_r == 5'(ITER - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, operand decode, divide fast path, sign fix and the
// registered register-file write port.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [4:0]      wrAddr,
  output logic [XLEN-1:0] wrData
);

  state_e            state_r, next_state_s;
  funct_e            op_r, op_in_s;
  logic [4:0]        rd_r, done_addr_s;
  logic              neg_r, neg_s, sa_s, sb_s;
  logic              accept_s, special_s, load_s, step_s, last_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, lo_s, opnd_s;
  logic [XLEN-1:0]   special_val_s, fix_val_s, quo_s, rem_s;
  logic [2*XLEN-1:0] acc_s, prod_s;
  logic              busy_r, done_r, we_r;
  logic [4:0]        wr_addr_r;
  logic [XLEN-1:0]   wr_data_r;

  // Request decode: magnitudes, result sign and divide special cases.
  always_comb begin
    op_in_s  = funct_e'(funct3);
    sa_s     = is_signed_a(op_in_s) && opA[XLEN-1];
    sb_s     = is_signed_b(op_in_s) && opB[XLEN-1];
    mag_a_s  = sa_s ? (32'd0 - opA) : opA;
    mag_b_s  = sb_s ? (32'd0 - opB) : opB;
    lo_s     = is_div(op_in_s) ? mag_a_s : mag_b_s;
    opnd_s   = is_div(op_in_s) ? mag_b_s : mag_a_s;
    neg_s    = is_rem(op_in_s) ? sa_s : (sa_s ^ sb_s);
    accept_s = (state_r == IDLE) && start && !flush;
    if (is_div(op_in_s) && (opB == 32'd0)) begin
      special_s     = 1'b1;
      special_val_s = is_rem(op_in_s) ? opA : DIV_ZERO_Q;
    end else if (is_div(op_in_s) && is_signed_a(op_in_s) &&
                 (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_val_s = is_rem(op_in_s) ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_val_s = 32'd0;
    end
  end

  // Next-state logic and datapath control.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && special_s) begin
          next_state_s = DONE;
        end else if (accept_s) begin
          next_state_s = CALC;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          next_state_s = IDLE;
        end else begin
          step_s       = 1'b1;
          next_state_s = last_s ? FIX : CALC;
        end
      end
      FIX:     next_state_s = flush ? IDLE : DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Sign correction and result selection, valid while in FIX.
  always_comb begin
    prod_s      = neg_r ? (64'd0 - acc_s) : acc_s;
    quo_s       = neg_r ? (32'd0 - acc_s[XLEN-1:0]) : acc_s[XLEN-1:0];
    rem_s       = neg_r ? (32'd0 - acc_s[2*XLEN-1:XLEN]) : acc_s[2*XLEN-1:XLEN];
    done_addr_s = (state_r == IDLE) ? rdIn : rd_r;
    case (op_r)
      MD_MUL:                        fix_val_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_val_s = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_val_s = quo_s;
      MD_REM, MD_REMU:               fix_val_s = rem_s;
      default:                       fix_val_s = prod_s[XLEN-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Captured request and registered outputs; wrAddr/wrData hold until the next completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r      <= MD_MUL;
      rd_r      <= 5'd0;
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      we_r      <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= 32'd0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
      we_r   <= (next_state_s == DONE) && (done_addr_s != 5'd0);
      if (accept_s) begin
        op_r  <= op_in_s;
        rd_r  <= rdIn;
        neg_r <= neg_s;
      end else begin
        op_r  <= op_r;
        rd_r  <= rd_r;
        neg_r <= neg_r;
      end
      if (accept_s && special_s) begin
        wr_addr_r <= rdIn;
        wr_data_r <= special_val_s;
      end else if ((state_r == FIX) && !flush) begin
        wr_addr_r <= rd_r;
        wr_data_r <= fix_val_s;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  muldiv_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .step      (step_s),
    .div_mode  (is_div(op_r)),
    .load_lo   (lo_s),
    .load_opnd (opnd_s),
    .acc       (acc_s),
    .last      (last_s)
  );

  assign busy   = busy_r;
  assign done   = done_r;
  assign we     = we_r;
  assign wrAddr = wr_addr_r;
  assign wrData = wr_data_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against an
// arithmetic reference model, and flush / reset / start-while-busy control scenarios.
module tb_muldiv_unit;

  logic        clk, rst, start, flush, busy, done, we;
  logic [2:0]  funct3;
  logic [31:0] opA, opB, wrData;
  logic [4:0]  rdIn, wrAddr;
  int checks = 0;
  int passed = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .opA(opA), .opB(opB),
    .rdIn(rdIn), .flush(flush), .busy(busy), .done(done), .we(we),
    .wrAddr(wrAddr), .wrData(wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat; } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint            sa, sb;
    longint unsigned   ua, ub;
    logic [63:0]       p;
    int                ia, ib, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = ia / ib; return r;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = ia % ib; return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request and wait (bounded) for done; lat counts edges from the start edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] data,
                        output logic [4:0] addr, output logic wev);
    funct3 = f; opA = a; opB = b; rdIn = rd; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    data = wrData; addr = wrAddr; wev = we;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0; opA = 32'd1; opB = 32'd1; rdIn = 5'd1;
    tick(); tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else passed++;
    checks++; if (wrAddr !== 5'd0) $display("FAIL reset_wraddr: got %0d want 0", wrAddr); else passed++;
    checks++; if (wrData !== 32'd0) $display("FAIL reset_wrdata: got %h want 0", wrData); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    vec_t        v[12];
    int          lat;
    logic [31:0] d;
    logic [4:0]  ad;
    logic        wv;
    v[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         34};
    v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34};
    v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34};
    v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34};
    v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    v[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,         34};
    v[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,          34};
    v[8]  = '{3'd5, 32'd100,        32'd0,          32'hFFFF_FFFF,  1};
    v[9]  = '{3'd6, 32'd100,        32'd0,          32'd100,        1};
    v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, 5'(i + 1), lat, d, ad, wv);
      checks++; if (d !== v[i].exp) $display("FAIL dir%0d_data: got %h want %h", i, d, v[i].exp); else passed++;
      checks++; if (lat !== v[i].lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); else passed++;
      checks++; if (ad !== 5'(i + 1) || wv !== 1'b1) $display("FAIL dir%0d_wport: got addr %0d we %b want addr %0d we 1", i, ad, wv, i + 1); else passed++;
    end
  endtask

  task automatic test_mul_timing();
    int   n = 0;
    int   done_at = 0;
    funct3 = 3'd0; opA = 32'd7; opB = 32'd6; rdIn = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done === 1'b1) begin
        done_at = n;
        checks++; if (we !== 1'b1 || wrAddr !== 5'd5 || wrData !== 32'd42)
          $display("FAIL mul_timing_out: got we %b addr %0d data %h want 1 5 2a", we, wrAddr, wrData); else passed++;
      end
      tick();
    end
    checks++; if (n !== 34) $display("FAIL mul_busy_cycles: got %0d want 34", n); else passed++;
    checks++; if (done_at !== 34) $display("FAIL mul_done_cycle: got %0d want 34", done_at); else passed++;
    checks++; if (done !== 1'b0 || we !== 1'b0) $display("FAIL mul_done_pulse: got done %b we %b want 0 0", done, we); else passed++;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, d;
    logic [4:0]  rd, ad;
    logic        wv;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); a = $urandom; rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(f, a, b, rd, lat, d, ad, wv);
      checks++; if (d !== model(f, a, b)) $display("FAIL rnd%0d_data f%0d a %h b %h: got %h want %h", i, f, a, b, d, model(f, a, b)); else passed++;
      checks++; if (lat !== model_lat(f, a, b)) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, model_lat(f, a, b)); else passed++;
      checks++; if (ad !== rd) $display("FAIL rnd%0d_wraddr: got %0d want %0d", i, ad, rd); else passed++;
      checks++; if (wv !== (rd != 5'd0)) $display("FAIL rnd%0d_we: got %b want %b", i, wv, rd != 5'd0); else passed++;
    end
  endtask

  task automatic test_flush();
    int          lat;
    logic [31:0] d;
    logic [4:0]  ad;
    logic        wv;
    funct3 = 3'd0; opA = 32'd9; opB = 32'd9; rdIn = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0)
      $display("FAIL flush_calc: got busy %b done %b we %b want 0 0 0", busy, done, we); else passed++;
    run_op(3'd5, 32'd1000, 32'd7, 5'd11, lat, d, ad, wv);
    checks++; if (d !== 32'd142 || ad !== 5'd11 || lat !== 34)
      $display("FAIL flush_restart: got data %h addr %0d lat %0d want 8e 11 34", d, ad, lat); else passed++;
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; opB = 32'd0;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_start_idle: got busy %b done %b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    funct3 = 3'd5; opA = 32'd77; opB = 32'd5; rdIn = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || wrAddr !== 5'd0 || wrData !== 32'd0)
      $display("FAIL reset_mid: got busy %b done %b we %b addr %0d data %h want all 0", busy, done, we, wrAddr, wrData); else passed++;
    rst = 1'b1;
    repeat (40) begin tick(); if (done === 1'b1) saw = 1'b1; end
    checks++; if (saw !== 1'b0) $display("FAIL reset_mid_nodone: got done seen %b want 0", saw); else passed++;
  endtask

  task automatic test_rd0();
    int          lat;
    logic [31:0] d;
    logic [4:0]  ad;
    logic        wv;
    run_op(3'd0, 32'd3, 32'd4, 5'd0, lat, d, ad, wv);
    checks++; if (lat !== 34 || wv !== 1'b0 || d !== 32'd12)
      $display("FAIL rd0: got lat %0d we %b data %h want 34 0 c", lat, wv, d); else passed++;
  endtask

  task automatic test_back_to_back();
    int   n = 1;
    logic saw = 1'b0;
    funct3 = 3'd0; opA = 32'd3; opB = 32'd5; rdIn = 5'd7; start = 1'b1;
    tick();
    funct3 = 3'd5; opA = 32'd1000; opB = 32'd3; rdIn = 5'd9;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n !== 34 || wrData !== 32'd15 || wrAddr !== 5'd7)
      $display("FAIL busy_start: got lat %0d data %h addr %0d want 34 f 7", n, wrData, wrAddr); else passed++;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL done_start_ignored: got busy %b want 0", busy); else passed++;
    repeat (40) begin tick(); if (done === 1'b1) saw = 1'b1; end
    checks++; if (saw !== 1'b0) $display("FAIL done_start_nodone: got done seen %b want 0", saw); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_timing();
    test_random();
    test_flush();
    test_reset_mid();
    test_rd0();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
